// File: rtl/alu_result_wb.sv
// alu_result_wb: write-back buffer for ALU results.
// A show-ahead FIFO holds {opcode, result, flags} between the ALU and the
// register-file write port. Alongside the FIFO the stage keeps a sticky
// overflow indicator, a one-cycle flag-consistency error pulse and a
// 16-bit count of accepted results.
//
// Handshake: both sides use valid/ready. A transfer happens on a rising
// edge where valid and ready are both 1. valid never depends on ready.
// in_ready is 1 whenever the FIFO is not full. When the FIFO is full,
// in_ready is 0 even if out_ready pops an entry in the same cycle, so
// there is no pop-through. out_valid is 1 whenever the FIFO holds at least
// one entry. The head entry is driven on out_* and stays stable until it
// is popped.
module alu_result_wb #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_result,
    input  logic [3:0]       in_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_opcode,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    input  logic             clr_sticky,
    output logic             sticky_ovf,
    output logic             flag_err,
    output logic [15:0]      acc_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Flag bit positions within {carry, zero, overflow, sign}.
    localparam int F_ZERO = 2;
    localparam int F_OVF  = 1;
    localparam int F_SIGN = 0;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [3:0]       opc_mem [DEPTH];
    logic [WIDTH-1:0] res_mem [DEPTH];
    logic [3:0]       flg_mem [DEPTH];

    logic             accept;
    logic             pop;
    logic             flags_bad;

    // Handshake qualifiers and the flag-consistency test on the incoming result.
    always_comb begin
        in_ready  = (count < (AW + 1)'(DEPTH));
        out_valid = (count != '0);
        accept    = in_valid && in_ready;
        pop       = out_valid && out_ready;
        flags_bad = (in_flags[F_ZERO] != (in_result == '0)) ||
                    (in_flags[F_SIGN] != in_result[WIDTH-1]);
    end

    // Show-ahead head. Storage resets to zero, so out_* reads zero after reset.
    always_comb begin
        out_opcode = opc_mem[rd_ptr];
        out_result = res_mem[rd_ptr];
        out_flags  = flg_mem[rd_ptr];
    end

    // Write side: store an accepted entry and advance the write pointer with wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                opc_mem[i] <= '0;
                res_mem[i] <= '0;
                flg_mem[i] <= '0;
            end
        end else if (accept) begin
            opc_mem[wr_ptr] <= in_opcode;
            res_mem[wr_ptr] <= in_result;
            flg_mem[wr_ptr] <= in_flags;
            if (wr_ptr == AW'(DEPTH - 1)) begin
                wr_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // Read side: advance the read pointer with wrap when the head is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (pop) begin
            if (rd_ptr == AW'(DEPTH - 1)) begin
                rd_ptr <= '0;
            end else begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy. An accept and a pop in the same cycle leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (accept && !pop) begin
            count <= count + 1'b1;
        end else if (pop && !accept) begin
            count <= count - 1'b1;
        end
    end

    // Sticky overflow. An overflow accept wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
        end else if (accept && in_flags[F_OVF]) begin
            sticky_ovf <= 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
        end
    end

    // Flag-consistency pulse in the cycle after an inconsistent accept. All opcodes are checked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_err <= 1'b0;
        end else begin
            flag_err <= accept && flags_bad;
        end
    end

    // Accepted-result counter. It wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_count <= '0;
        end else if (accept) begin
            acc_count <= acc_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_result_wb.sv
// tb_alu_result_wb: self-checking bench for alu_result_wb.
// A queue-based reference model predicts occupancy, head data, sticky
// overflow, the flag error pulse and the accept count.
module tb_alu_result_wb;

    localparam int W = 64;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_opcode;
    logic [W-1:0] in_result;
    logic [3:0]   in_flags;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_opcode;
    logic [W-1:0] out_result;
    logic [3:0]   out_flags;
    logic         clr_sticky;
    logic         sticky_ovf;
    logic         flag_err;
    logic [15:0]  acc_count;

    alu_result_wb #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_result  (in_result),
        .in_flags   (in_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_result (out_result),
        .out_flags  (out_flags),
        .clr_sticky (clr_sticky),
        .sticky_ovf (sticky_ovf),
        .flag_err   (flag_err),
        .acc_count  (acc_count)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model state: each entry is {opcode, flags, result}.
    logic [W+7:0] exp_q[$];
    int           m_acc;
    logic         m_sticky;
    logic         m_err;
    bit           chk_en;

    int checks;
    int errors;

    typedef struct {
        logic [3:0]   opc;
        logic [W-1:0] res;
        logic [3:0]   flg;
        logic         exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [W+7:0] act, input logic [W+7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] opc, input logic [W-1:0] res, input logic [3:0] flg);
        in_valid  = v;
        in_opcode = opc;
        in_result = res;
        in_flags  = flg;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_acc    = 0;
        m_sticky = 1'b0;
        m_err    = 1'b0;
    endtask

    // Runs one clock cycle. Inputs must already be driven. Outputs are
    // compared at the falling edge, and the model is updated at the rising
    // edge. The task returns 1 time unit after the rising edge.
    task automatic cycle();
        logic         acc, pop, clr, bad;
        logic [W+7:0] head, ent;
        @(negedge clk);
        if (chk_en) begin
            check("in_ready", W'(in_ready), W'(exp_q.size() < D));
            check("out_valid", W'(out_valid), W'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                head = exp_q[0];
                check("out_opcode", W'(out_opcode), W'(head[W+7:W+4]));
                check("out_flags", W'(out_flags), W'(head[W+3:W]));
                check("out_result", W'(out_result), W'(head[W-1:0]));
            end
            check("sticky_ovf", W'(sticky_ovf), W'(m_sticky));
            check("flag_err", W'(flag_err), W'(m_err));
            check("acc_count", W'(acc_count), W'(m_acc % 65536));
        end
        acc = in_valid && (exp_q.size() < D);
        pop = out_ready && (exp_q.size() > 0);
        clr = clr_sticky;
        ent = {in_opcode, in_flags, in_result};
        bad = (in_flags[2] != (in_result == 0)) || (in_flags[0] != in_result[W-1]);
        @(posedge clk);
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
            exp_q.push_back(ent);
            m_acc++;
        end
        m_err = acc && bad;
        if (acc && ent[W+1]) m_sticky = 1'b1;
        else if (clr) m_sticky = 1'b0;
        #1;
    endtask

    task automatic rand_entry(output logic [3:0] opc, output logic [W-1:0] res, output logic [3:0] flg);
        int sel;
        sel = $urandom_range(0, 3);
        opc = 4'($urandom_range(0, 15));
        if (sel == 0) res = '0;
        else if (sel == 1) res = {1'b1, 31'($urandom), 32'($urandom)};
        else res = {32'($urandom), 32'($urandom)};
        flg = 4'($urandom);
        if ($urandom_range(0, 1) == 1) begin
            flg[2] = (res == 0);
            flg[0] = res[W-1];
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < D + 2; i++) cycle();
    endtask

    initial begin
        logic [3:0]   opc;
        logic [W-1:0] res;
        logic [3:0]   flg;
        int           base;
        int           n;

        checks = 0;
        errors = 0;
        chk_en = 1'b1;
        model_reset();

        vecs[0] = '{4'd5,  64'h3,                  4'b0000, 1'b0};
        vecs[1] = '{4'd0,  64'h0,                  4'b0100, 1'b0};
        vecs[2] = '{4'd1,  64'h0,                  4'b0010, 1'b1};
        vecs[3] = '{4'd2,  64'h8000_0000_0000_0000, 4'b0001, 1'b0};
        vecs[4] = '{4'd3,  64'h8000_0000_0000_0000, 4'b0000, 1'b1};
        vecs[5] = '{4'd10, 64'h1,                  4'b0100, 1'b1};
        vecs[6] = '{4'd15, 64'h0,                  4'b1100, 1'b0};
        vecs[7] = '{4'd12, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1101, 1'b1};

        // Reset asserted between edges; outputs must clear at once.
        rst_n = 1'b1;
        out_ready = 1'b0;
        clr_sticky = 1'b0;
        drive(1'b1, 4'd7, 64'h55, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_acc_count", W'(acc_count), W'(0));
        check("rst_sticky", W'(sticky_ovf), W'(0));
        check("rst_flag_err", W'(flag_err), W'(0));
        check("rst_out_data", {out_opcode, out_flags, out_result}, '0);
        // No accept while rst_n is low, even with in_valid high.
        @(posedge clk); #1;
        check("rst_no_accept", W'(acc_count), W'(0));
        rst_n = 1'b1;
        in_valid = 1'b0;
        cycle();

        // Single pass: opcode 5, result 3, flags 0000.
        out_ready = 1'b1;
        drive(1'b1, 4'd5, 64'h3, 4'b0000);
        cycle();
        in_valid = 1'b0;
        check("single_valid", W'(out_valid), W'(1));
        check("single_result", out_result, W'(64'h3));
        check("single_opcode", W'(out_opcode), W'(5));
        check("single_count", W'(acc_count), W'(1));
        check("single_flag_err", W'(flag_err), W'(0));
        cycle();
        drain();

        // Table of flag-consistency vectors.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].opc, vecs[i].res, vecs[i].flg);
            cycle();
            in_valid = 1'b0;
            check("tbl_flag_err", W'(flag_err), W'(vecs[i].exp_err));
            check("tbl_head", {out_opcode, out_flags, out_result}, {vecs[i].opc, vecs[i].flg, vecs[i].res});
            cycle();
        end
        drain();

        // Fill and stall: offer 1..5 with the sink stalled.
        base = m_acc;
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 4'd4, W'(i), 4'b0000);
            cycle();
        end
        check("fill_in_ready", W'(in_ready), W'(0));
        check("fill_head", out_result, W'(1));
        out_ready = 1'b1;
        cycle();
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        check("fill_count", W'(acc_count), W'(base + 5));
        check("fill_empty", W'(out_valid), W'(0));

        // Streaming at occupancy 2.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_entry(opc, res, flg);
            drive(1'b1, opc, res, flg);
            cycle();
        end
        base = m_acc;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_entry(opc, res, flg);
            drive(1'b1, opc, res, flg);
            cycle();
        end
        check("stream_count", W'(acc_count), W'(base + 10));
        drain();

        // Sticky overflow and the flag error pulse.
        drive(1'b1, 4'd6, 64'h0, 4'b0010);
        cycle();
        in_valid = 1'b0;
        check("sticky_set", W'(sticky_ovf), W'(1));
        check("err_pulse", W'(flag_err), W'(1));
        cycle();
        check("err_one_cycle", W'(flag_err), W'(0));
        clr_sticky = 1'b1;
        drive(1'b1, 4'd6, 64'h7, 4'b0010);
        cycle();
        in_valid = 1'b0;
        check("sticky_set_wins", W'(sticky_ovf), W'(1));
        cycle();
        check("sticky_cleared", W'(sticky_ovf), W'(0));
        clr_sticky = 1'b0;
        drain();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rand_entry(opc, res, flg);
            drive(1'(($urandom_range(0, 3)) != 0), opc, res, flg);
            out_ready  = 1'(($urandom_range(0, 2)) != 0);
            clr_sticky = 1'(($urandom_range(0, 7)) == 0);
            cycle();
        end
        clr_sticky = 1'b0;
        drain();

        // Reset in mid-operation with 3 entries buffered.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd9, W'(100 + i), 4'b0000);
            cycle();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", W'(out_valid), W'(0));
        check("mid_rst_in_ready", W'(in_ready), W'(1));
        check("mid_rst_count", W'(acc_count), W'(0));
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b1, 4'd11, 64'hABCD, 4'b0000);
        cycle();
        in_valid = 1'b0;
        check("post_rst_head", out_result, W'(64'hABCD));
        check("post_rst_depth", W'(in_ready), W'(1));
        cycle();
        drain();

        // Counter wrap over 65536 accepts, with random data, while streaming.
        chk_en = 1'b0;
        out_ready = 1'b1;
        n = 65536 - (m_acc % 65536);
        for (int i = 0; i < n; i++) begin
            rand_entry(opc, res, flg);
            drive(1'b1, opc, res, flg);
            cycle();
        end
        in_valid = 1'b0;
        chk_en = 1'b1;
        check("wrap_count", W'(acc_count), W'(0));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
